// File: rtl/thresh_pkg.sv
// thresh_pkg: shared types and default widths for multi_threshold_detect.
//   thresh_state_e : per-channel detector state (IDLE, WINDOW, REPORT)
//   DEF_*          : default parameter values for channel count and widths
package thresh_pkg;

  localparam int unsigned DEF_N_CH = 32'd4;
  localparam int unsigned DEF_DW   = 32'd32;
  localparam int unsigned DEF_TW   = 32'd32;
  localparam int unsigned DEF_HW   = 32'd16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_REPORT = 2'd2
  } thresh_state_e;

endpackage

// File: rtl/threshold_channel.sv
// threshold_channel: one channel of the multi-threshold event detector.
// Opens a window on sample > high, tracks the earliest maximum and its
// timestamp, closes after max(hold,1) consecutive quiet samples and holds the
// report until acknowledged.
// Optional feature macro: THRESH_OVERRUN_EN (sticky overrun flag).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   sample        : this channel's sample
//   sample_valid  : sample strobe
//   timestamp     : timestamp of the current sample
//   high, low     : open / quiet thresholds (unsigned, live)
//   hold          : required consecutive quiet samples (0 acts as 1)
//   ack           : report acknowledge
//   valid         : report pending
//   detect_time   : timestamp of the reported peak
//   peak_value    : reported peak value
//   overrun       : sticky lost-event flag (0 when feature not built)
module threshold_channel
  import thresh_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned TW = DEF_TW,
  parameter int unsigned HW = DEF_HW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] sample,
  input  logic          sample_valid,
  input  logic [TW-1:0] timestamp,
  input  logic [DW-1:0] high,
  input  logic [DW-1:0] low,
  input  logic [HW-1:0] hold,
  input  logic          ack,
  output logic          valid,
  output logic [TW-1:0] detect_time,
  output logic [DW-1:0] peak_value,
  output logic          overrun
);

  localparam logic [HW-1:0] HOLD_ONE = {{(HW-1){1'b0}}, 1'b1};

  thresh_state_e state_r;
  logic [DW-1:0] max_r;
  logic [TW-1:0] max_t_r;
  logic [HW-1:0] quiet_r;
  logic          valid_r;
  logic [TW-1:0] detect_time_r;
  logic [DW-1:0] peak_value_r;

  logic [HW-1:0] hold_eff_s;
  logic          above_high_s;
  logic          quiet_hit_s;
  logic          quiet_sat_s;
  logic [HW-1:0] quiet_inc_s;
  logic          close_s;
  logic [DW-1:0] max_next_s;
  logic [TW-1:0] max_t_next_s;

  // Window bookkeeping: quiet classification, saturating count, peak update, close
  always_comb begin
    hold_eff_s   = hold;
    above_high_s = (sample > high);
    // A sample above high never counts as quiet, even when low > high.
    quiet_hit_s  = (sample < low) && !above_high_s;
    quiet_sat_s  = (quiet_r == {HW{1'b1}});
    quiet_inc_s  = quiet_r;
    max_next_s   = max_r;
    max_t_next_s = max_t_r;
    close_s      = 1'b0;
    if (hold == {HW{1'b0}}) begin
      hold_eff_s = HOLD_ONE;
    end else begin
      hold_eff_s = hold;
    end
    if (quiet_sat_s) begin
      quiet_inc_s = quiet_r;
    end else begin
      quiet_inc_s = quiet_r + HOLD_ONE;
    end
    // Strict compare keeps the earliest of equal peaks.
    if (sample > max_r) begin
      max_next_s   = sample;
      max_t_next_s = timestamp;
    end else begin
      max_next_s   = max_r;
      max_t_next_s = max_t_r;
    end
    if (quiet_hit_s && !quiet_sat_s && (quiet_inc_s == hold_eff_s)) begin
      close_s = 1'b1;
    end else begin
      close_s = 1'b0;
    end
  end

  // Channel FSM with registered report outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      max_r         <= {DW{1'b0}};
      max_t_r       <= {TW{1'b0}};
      quiet_r       <= {HW{1'b0}};
      valid_r       <= 1'b0;
      detect_time_r <= {TW{1'b0}};
      peak_value_r  <= {DW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sample_valid && above_high_s) begin
            max_r   <= sample;
            max_t_r <= timestamp;
            quiet_r <= {HW{1'b0}};
            state_r <= ST_WINDOW;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WINDOW: begin
          if (sample_valid) begin
            max_r   <= max_next_s;
            max_t_r <= max_t_next_s;
            if (close_s) begin
              quiet_r       <= quiet_inc_s;
              detect_time_r <= max_t_next_s;
              peak_value_r  <= max_next_s;
              valid_r       <= 1'b1;
              state_r       <= ST_REPORT;
            end else if (quiet_hit_s) begin
              quiet_r <= quiet_inc_s;
            end else begin
              quiet_r <= {HW{1'b0}};
            end
          end else begin
            state_r <= ST_WINDOW;
          end
        end
        ST_REPORT: begin
          // Any sample in the ack cycle is dropped.
          if (ack) begin
            valid_r <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_REPORT;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef THRESH_OVERRUN_EN
  logic overrun_r;

  // Sticky flag: a new crossing while a report is still pending is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r <= 1'b0;
    end else if ((state_r == ST_REPORT) && !ack && sample_valid && above_high_s) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign overrun = overrun_r;
`else
  assign overrun = 1'b0;
`endif

  assign valid       = valid_r;
  assign detect_time = detect_time_r;
  assign peak_value  = peak_value_r;

endmodule

// File: rtl/multi_threshold_detect.sv
// multi_threshold_detect: N_CH independent threshold/hysteresis event
// detectors sharing one sample timer, for comparing arrival times across
// microphones.
// Optional feature macro: THRESH_OVERRUN_EN (per-channel sticky overrun).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   data         : N_CH samples, channel c at [c*DW +: DW]
//   data_valid   : shared sample strobe
//   high, low    : window-open / quiet thresholds
//   hold         : consecutive quiet samples needed to close (0 acts as 1)
//   ack          : per-channel report acknowledge
//   valid        : per-channel report pending
//   detect_time  : per-channel peak timestamp, channel c at [c*TW +: TW]
//   peak_value   : per-channel peak value, channel c at [c*DW +: DW]
//   overrun      : per-channel sticky lost-event flag
module multi_threshold_detect
  import thresh_pkg::*;
#(
  parameter int unsigned N_CH = DEF_N_CH,
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned TW   = DEF_TW,
  parameter int unsigned HW   = DEF_HW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH*DW-1:0] data,
  input  logic               data_valid,
  input  logic [DW-1:0]      high,
  input  logic [DW-1:0]      low,
  input  logic [HW-1:0]      hold,
  input  logic [N_CH-1:0]    ack,
  output logic [N_CH-1:0]    valid,
  output logic [N_CH*TW-1:0] detect_time,
  output logic [N_CH*DW-1:0] peak_value,
  output logic [N_CH-1:0]    overrun
);

  localparam logic [TW-1:0] TIMER_ONE = {{(TW-1){1'b0}}, 1'b1};

  logic [TW-1:0] timer_r;

  // Shared sample timer; the current value is the timestamp of the present sample
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r <= {TW{1'b0}};
    end else if (data_valid) begin
      timer_r <= timer_r + TIMER_ONE;
    end else begin
      timer_r <= timer_r;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    threshold_channel #(
      .DW(DW),
      .TW(TW),
      .HW(HW)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .sample       (data[c*DW +: DW]),
      .sample_valid (data_valid),
      .timestamp    (timer_r),
      .high         (high),
      .low          (low),
      .hold         (hold),
      .ack          (ack[c]),
      .valid        (valid[c]),
      .detect_time  (detect_time[c*TW +: TW]),
      .peak_value   (peak_value[c*DW +: DW]),
      .overrun      (overrun[c])
    );
  end

endmodule

// File: tb/tb_multi_threshold_detect.sv
// tb_multi_threshold_detect: directed scenarios plus randomized traffic for
// multi_threshold_detect, checked every cycle against a window-history model.
module tb_multi_threshold_detect;

  localparam int NC = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [127:0]   data;
  logic           data_valid;
  logic [31:0]    high;
  logic [31:0]    low;
  logic [15:0]    hold;
  logic [3:0]     ack;
  logic [3:0]     valid;
  logic [127:0]   detect_time;
  logic [127:0]   peak_value;
  logic [3:0]     overrun;

  int n_cmp = 0;
  int n_err = 0;

  multi_threshold_detect dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .data_valid  (data_valid),
    .high        (high),
    .low         (low),
    .hold        (hold),
    .ack         (ack),
    .valid       (valid),
    .detect_time (detect_time),
    .peak_value  (peak_value),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

`ifdef THRESH_OVERRUN_EN
  localparam bit OVR_EXP = 1'b1;
`else
  localparam bit OVR_EXP = 1'b0;
`endif

  // Model: every window is kept as its full sample history
  typedef struct {
    logic [31:0] v;
    logic [31:0] t;
    bit          q;
  } ent_t;

  ent_t        win_q[NC][$];
  bit          in_win[NC];
  bit          rep[NC];
  bit          e_val[NC];
  bit          e_ovr[NC];
  logic [31:0] e_dt[NC];
  logic [31:0] e_pk[NC];
  logic [31:0] m_timer;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] s;
    ent_t        e;
    int          run;
    int          best;
    int          heff;
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        win_q[c].delete();
        in_win[c] = 1'b0; rep[c] = 1'b0; e_val[c] = 1'b0; e_ovr[c] = 1'b0;
        e_dt[c] = 32'd0; e_pk[c] = 32'd0;
      end
      m_timer = 32'd0;
    end else begin
      heff = (hold == 16'd0) ? 1 : int'(hold);
      for (int c = 0; c < NC; c++) begin
        s = data[c*32 +: 32];
        if (rep[c]) begin
          if (ack[c]) begin
            rep[c] = 1'b0;
            e_val[c] = 1'b0;
          end
`ifdef THRESH_OVERRUN_EN
          else if (data_valid && (s > high)) begin
            e_ovr[c] = 1'b1;
          end
`endif
        end else if (in_win[c]) begin
          if (data_valid) begin
            e.v = s; e.t = m_timer; e.q = (s < low) && !(s > high);
            win_q[c].push_back(e);
            run = 0;
            for (int i = win_q[c].size() - 1; i >= 0; i--) begin
              if (win_q[c][i].q) run++;
              else break;
            end
            if (e.q && run == heff) begin
              best = 0;
              for (int i = 1; i < win_q[c].size(); i++)
                if (win_q[c][i].v > win_q[c][best].v) best = i;
              e_dt[c] = win_q[c][best].t;
              e_pk[c] = win_q[c][best].v;
              e_val[c] = 1'b1;
              rep[c] = 1'b1;
              in_win[c] = 1'b0;
              win_q[c].delete();
            end
          end
        end else if (data_valid && (s > high)) begin
          in_win[c] = 1'b1;
          win_q[c].delete();
          e.v = s; e.t = m_timer; e.q = 1'b0;
          win_q[c].push_back(e);
        end
      end
      if (data_valid) m_timer = m_timer + 32'd1;
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("valid%0d", c), 64'(valid[c]), 64'(e_val[c]));
      chk($sformatf("dt%0d", c), 64'(detect_time[c*32 +: 32]), 64'(e_dt[c]));
      chk($sformatf("pk%0d", c), 64'(peak_value[c*32 +: 32]), 64'(e_pk[c]));
    end
    chk("overrun", 64'(overrun), 64'({e_ovr[3], e_ovr[2], e_ovr[1], e_ovr[0]}));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] s3,
                       input logic dv_i, input logic [3:0] ack_i);
    data = {s3, s2, s1, s0};
    data_valid = dv_i;
    ack = ack_i;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] seq1[7];
    logic [31:0] seq2[6];
    logic [31:0] seq3[8];
    logic [31:0] s[4];
    seq1 = '{32'd5, 32'd120, 32'd300, 32'd250, 32'd0, 32'd0, 32'd0};
    seq2 = '{32'd200, 32'd30, 32'd70, 32'd30, 32'd30, 32'd30};
    seq3 = '{32'd0, 32'd300, 32'd200, 32'd200, 32'd300, 32'd0, 32'd0, 32'd0};
    rst = 1'b1; data = '0; data_valid = 1'b0; ack = 4'd0;
    high = 32'd100; low = 32'd50; hold = 16'd3;
    do_reset();
    do_reset();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);

    // Basic event on ch0
    for (int i = 0; i < 7; i++) drive(seq1[i], 32'd0, 32'd0, 32'd0, 1'b1, 4'd0);
    chk("basic_valid", 64'(valid[0]), 64'd1);
    chk("basic_dt", 64'(detect_time[31:0]), 64'd2);
    chk("basic_pk", 64'(peak_value[31:0]), 64'd300);
    drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0001);
    chk("basic_ack", 64'(valid[0]), 64'd0);

    // Hysteresis: the 70 restarts the quiet count
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(seq2[i], 32'd0, 32'd0, 32'd0, 1'b1, 4'd0);
      if (i == 4) chk("hyst_early", 64'(valid[0]), 64'd0);
    end
    chk("hyst_valid", 64'(valid[0]), 64'd1);
    chk("hyst_pk", 64'(peak_value[31:0]), 64'd200);

    // Tie: earliest of equal peaks is reported
    do_reset();
    for (int i = 0; i < 8; i++) drive(seq3[i], 32'd0, 32'd0, 32'd0, 1'b1, 4'd0);
    chk("tie_valid", 64'(valid[0]), 64'd1);
    chk("tie_dt", 64'(detect_time[31:0]), 64'd1);

    // Two channels offset by 7 samples
    do_reset();
    for (int i = 0; i < 14; i++)
      drive((i == 1) ? 32'd300 : 32'd0, (i == 8) ? 32'd300 : 32'd0, 32'd0, 32'd0, 1'b1, 4'd0);
    chk("two_valid", 64'(valid[1:0]), 64'd3);
    chk("two_delta", 64'(detect_time[63:32] - detect_time[31:0]), 64'd7);
    drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0010);
    chk("two_ack1", 64'(valid[1:0]), 64'd1);

    // Overrun: crossing while ch0 still reports
    drive(32'd500, 32'd0, 32'd0, 32'd0, 1'b1, 4'd0);
    chk("ovr_set", 64'(overrun[0]), 64'(OVR_EXP));
    drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0001);
    chk("ovr_sticky", 64'(overrun[0]), 64'(OVR_EXP));
    chk("ovr_ack", 64'(valid[0]), 64'd0);

    // Reset in the middle of a window discards the event
    drive(32'd400, 32'd400, 32'd0, 32'd0, 1'b1, 4'd0);
    drive(32'd10, 32'd10, 32'd0, 32'd0, 1'b1, 4'd0);
    rst = 1'b1;
    drive(32'd10, 32'd10, 32'd0, 32'd0, 1'b1, 4'd0);
    rst = 1'b0;
    chk("rstmid_valid", 64'(valid), 64'd0);
    chk("rstmid_ovr", 64'(overrun), 64'd0);
    chk("rstmid_pk", 64'(peak_value[31:0]), 64'd0);
    for (int i = 0; i < 5; i++) drive(32'd10, 32'd10, 32'd0, 32'd0, 1'b1, 4'd0);
    chk("rstmid_none", 64'(valid), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        high = $urandom_range(50, 250);
        low  = $urandom_range(70, 300);
        hold = 16'($urandom_range(0, 5));
      end
      for (int c = 0; c < NC; c++)
        s[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 60) : $urandom_range(0, 400);
      rst = ($urandom_range(0, 499) == 0);
      drive(s[0], s[1], s[2], s[3], ($urandom_range(0, 4) != 0),
            {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
